// File: rtl/sd_pkg.sv
// Shared definitions for the SD DAT0 data path: FSM states, result codes,
// CRC16 polynomial and CRC status tokens.
package sd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CRC,
    S_END,
    S_TURN,
    S_STAT,
    S_BUSY,
    S_DONE
  } sd_state_e;

  localparam logic [2:0] ERR_OK       = 3'd0;
  localparam logic [2:0] ERR_CRC      = 3'd1;
  localparam logic [2:0] ERR_TOKEN    = 3'd2;
  localparam logic [2:0] ERR_STAT_TMO = 3'd3;
  localparam logic [2:0] ERR_BUSY_TMO = 3'd4;
  localparam logic [2:0] ERR_UNDERRUN = 3'd5;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] CRC16_POLY = 16'h1021;

  localparam logic [2:0] ST_OK     = 3'b010;
  localparam logic [2:0] ST_CRCERR = 3'b101;

  // One serial CRC16 step: shift left, fold in the feedback bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16_ser.sv
// Serial CRC16 LFSR (init 0, no final XOR), shared with the receive path.
module sd_crc16_ser
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  // Synchronous clear has priority over a shift.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_data_tx.sv
// SD DAT0 write transmitter, 1-bit bus: start bit, block data, CRC16, end bit,
// then CRC status token capture and busy wait. Bus activity advances on sd_ce.
module sd_data_tx
  import sd_pkg::*;
#(
  parameter int unsigned BLK_BYTES    = 512,
  parameter int unsigned STAT_TIMEOUT = 64,
  parameter int unsigned BUSY_TIMEOUT = 1 << 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sd_ce,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dat_o,
  output logic       dat_oe,
  input  logic       dat_i,
  output logic       busy,
  output logic       done,
  output logic [2:0] err
);

  localparam int unsigned BCW     = (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
  localparam int unsigned TMO_MAX = (STAT_TIMEOUT > BUSY_TIMEOUT) ? STAT_TIMEOUT : BUSY_TIMEOUT;
  localparam int unsigned TW      = (TMO_MAX > 1) ? $clog2(TMO_MAX) : 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BLK_BYTES - 1);
  localparam logic [TW-1:0]  STAT_LAST = TW'(STAT_TIMEOUT - 1);
  localparam logic [TW-1:0]  BUSY_LAST = TW'(BUSY_TIMEOUT - 1);

  sd_state_e      state;
  logic [BCW-1:0] byte_cnt;
  logic [3:0]     bit_cnt;
  logic [7:0]     hold;
  logic           hold_full;
  logic [15:0]    sh;
  logic [2:0]     tok;
  logic           stat_hunt;
  logic [TW-1:0]  tmo;

  logic [15:0]    crc;
  logic           crc_clr;
  logic           crc_en;
  logic           crc_bit;
  logic           boundary;
  logic           take;

  assign in_ready = !hold_full && ((state == S_START) || (state == S_DATA));
  assign take     = in_valid && in_ready;

  // CRC is fed with exactly the bit being driven on this tick, so it is final
  // by the tick that starts the CRC field.
  always_comb begin
    boundary = sd_ce && (((state == S_START) && (bit_cnt == 4'd1)) ||
                         ((state == S_DATA) && (bit_cnt == 4'd7) && (byte_cnt != LAST_BYTE)));
    crc_en   = (boundary && hold_full) || (sd_ce && (state == S_DATA) && (bit_cnt != 4'd7));
    crc_bit  = boundary ? hold[7] : sh[15];
    crc_clr  = (state == S_IDLE) && start;
  end

  sd_crc16_ser u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc)
  );

  // Transfer sequencer; dat_o holds the value on the wire for the current bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dat_o     <= 1'b1;
      dat_oe    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= ERR_OK;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      sh        <= '0;
      tok       <= '0;
      stat_hunt <= 1'b1;
      tmo       <= '0;
    end else begin
      if (take) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          dat_o  <= 1'b1;
          dat_oe <= 1'b1;
          if (start) begin
            state     <= S_START;
            busy      <= 1'b1;
            err       <= ERR_OK;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            hold_full <= 1'b0;
          end
        end
        S_START: if (sd_ce) begin
          if (bit_cnt == 4'd0) begin
            dat_o   <= 1'b0;
            bit_cnt <= 4'd1;
          end else if (hold_full) begin
            dat_o     <= hold[7];
            sh        <= {hold[6:0], 9'b0};
            hold_full <= 1'b0;
            bit_cnt   <= 4'd0;
            state     <= S_DATA;
          end else begin
            err   <= ERR_UNDERRUN;
            dat_o <= 1'b1;
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DATA: if (sd_ce) begin
          if (bit_cnt != 4'd7) begin
            dat_o   <= sh[15];
            sh      <= {sh[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (byte_cnt == LAST_BYTE) begin
            dat_o   <= crc[15];
            sh      <= {crc[14:0], 1'b0};
            bit_cnt <= 4'd0;
            state   <= S_CRC;
          end else if (hold_full) begin
            dat_o     <= hold[7];
            sh        <= {hold[6:0], 9'b0};
            hold_full <= 1'b0;
            bit_cnt   <= 4'd0;
            byte_cnt  <= byte_cnt + 1'b1;
          end else begin
            err   <= ERR_UNDERRUN;
            dat_o <= 1'b1;
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_CRC: if (sd_ce) begin
          if (bit_cnt == 4'd15) begin
            dat_o <= 1'b1;
            state <= S_END;
          end else begin
            dat_o   <= sh[15];
            sh      <= {sh[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        S_END: if (sd_ce) begin
          dat_oe  <= 1'b0;
          bit_cnt <= 4'd0;
          state   <= S_TURN;
        end
        S_TURN: if (sd_ce) begin
          if (bit_cnt == 4'd1) begin
            state     <= S_STAT;
            tmo       <= '0;
            stat_hunt <= 1'b1;
            bit_cnt   <= 4'd0;
          end else begin
            bit_cnt <= 4'd1;
          end
        end
        S_STAT: if (sd_ce) begin
          if (stat_hunt) begin
            if (!dat_i) begin
              stat_hunt <= 1'b0;
              bit_cnt   <= 4'd0;
            end else if (tmo == STAT_LAST) begin
              err    <= ERR_STAT_TMO;
              dat_o  <= 1'b1;
              dat_oe <= 1'b1;
              state  <= S_DONE;
              done   <= 1'b1;
              busy   <= 1'b0;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end else if (bit_cnt != 4'd3) begin
            tok     <= {tok[1:0], dat_i};
            bit_cnt <= bit_cnt + 4'd1;
          end else if ((tok == ST_OK) && dat_i) begin
            tmo   <= '0;
            state <= S_BUSY;
          end else begin
            err    <= (tok == ST_CRCERR) ? ERR_CRC : ERR_TOKEN;
            dat_o  <= 1'b1;
            dat_oe <= 1'b1;
            state  <= S_DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end
        S_BUSY: if (sd_ce) begin
          if (dat_i || (tmo == BUSY_LAST)) begin
            if (!dat_i) err <= ERR_BUSY_TMO;
            dat_o  <= 1'b1;
            dat_oe <= 1'b1;
            state  <= S_DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
